alarma_temporizada: RTL and testbench

Parametrised, clocked car-alarm controller for N doors, with arming delay, entry delay and time-limited siren. It evaluates the alarm trigger conditions of the combinational alarm lesson (closed doors with the boot open; handbrake off with the engine running and any door open). It adds a Moore state machine and a saturating trigger counter on top. It is the sequential lesson of the combinational-examples series and is driven by the same switch-level inputs.

---
 rtl/alarma_temporizada_pkg.sv | 25 ++
 rtl/alarma_temporizada_if.sv | 29 ++
 rtl/alarma_temporizada_temporizador.sv | 38 +++
 rtl/alarma_temporizada.sv | 116 +++++++++++
 tb/tb_alarma_temporizada.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/alarma_temporizada_pkg.sv
// alarma_temporizada_pkg
// Shared definitions for the timed car-alarm controller:
//   - estado_t : 3-bit Moore state encoding (E_DESARMADA .. E_SONANDO)
//   - cnt_width: width of the shared down-counter, sized for the longest delay
package alarma_temporizada_pkg;

  typedef enum logic [2:0] {
    E_DESARMADA  = 3'd0,
    E_ARMANDO    = 3'd1,
    E_VIGILANCIA = 3'd2,
    E_ESPERA     = 3'd3,
    E_SONANDO    = 3'd4
  } estado_t;

  // The counter only ever holds delay-1, so ceil(log2(max delay)) bits suffice.
  // A delay of 1 still needs a 1-bit counter.
  function automatic int cnt_width(input int t_arm, input int t_entry, input int t_siren);
    int mx;
    mx = t_arm;
    if (t_entry > mx) mx = t_entry;
    if (t_siren > mx) mx = t_siren;
    return (mx <= 2) ? 1 : $clog2(mx);
  endfunction

endpackage

// File: rtl/alarma_temporizada_if.sv
// alarma_temporizada_if
// Switch-level inputs and alarm outputs of the controller.
//   c        : alarm control (1 = connected)
//   p[NP]    : doors, bit i = 1 -> door i open
//   t        : engine on
//   m        : boot open
//   f        : handbrake set
//   a        : siren
//   armada   : alarm armed (watching)
//   aviso    : entry-delay warning
//   disparos : saturating count of siren activations
// master = the car/switch side, slave = the controller.
interface alarma_temporizada_if #(
  parameter int NP = 2,
  parameter int CW = 4
);
  logic          c;
  logic [NP-1:0] p;
  logic          t;
  logic          m;
  logic          f;
  logic          a;
  logic          armada;
  logic          aviso;
  logic [CW-1:0] disparos;

  modport master (output c, p, t, m, f, input a, armada, aviso, disparos);
  modport slave  (input c, p, t, m, f, output a, armada, aviso, disparos);
endinterface

// File: rtl/alarma_temporizada_temporizador.sv
// temporizador
// Loadable down-counter shared by every timed state of the alarm.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset (counter -> 0)
//   load    : load valor this edge (takes priority over counting)
//   valor   : value to load
//   cero    : counter is zero
// The counter stops at zero instead of wrapping, so idle states that never
// reload it simply sit at zero.
module temporizador #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] valor,
  output logic         cero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = valor;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cero = (cnt_q == '0);

endmodule

// File: rtl/alarma_temporizada.sv
// alarma_temporizada
// Timed car-alarm controller: arming delay, entry delay, time-limited siren and
// a saturating count of siren activations.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : alarma_temporizada_if.slave (c, p, t, m, f in; a, armada, aviso,
//             disparos out)
// Trigger: boot open with all doors closed, or handbrake released with the
// engine running and any door open. Outputs are decoded from registered state.
module alarma_temporizada
  import alarma_temporizada_pkg::*;
#(
  parameter int NP      = 2,
  parameter int T_ARM   = 8,
  parameter int T_ENTRY = 4,
  parameter int T_SIREN = 16,
  parameter int CW      = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  alarma_temporizada_if.slave  bus
);

  localparam int W = cnt_width(T_ARM, T_ENTRY, T_SIREN);
  localparam logic [W-1:0] V_ARM   = W'(T_ARM - 1);
  localparam logic [W-1:0] V_ENTRY = W'(T_ENTRY - 1);
  localparam logic [W-1:0] V_SIREN = W'(T_SIREN - 1);

  estado_t       state_q, state_d;
  logic [CW-1:0] disparos_q, disparos_d;
  logic [NP-1:0] doors;
  logic          pa, disp;
  logic          load;
  logic [W-1:0]  valor;
  logic          cero;

  assign doors = bus.p;
  assign pa    = |doors;
  assign disp  = (!pa & bus.m) | (!bus.f & bus.t & pa);

  temporizador #(.W(W)) u_temporizador (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .valor   (valor),
    .cero    (cero)
  );

  // Every state entry reloads the counter; entries into untimed states load 0.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    valor   = '0;
    unique case (state_q)
      E_DESARMADA: if (bus.c) begin
        state_d = E_ARMANDO;
        load    = 1'b1;
        valor   = V_ARM;
      end
      E_ARMANDO: if (cero) begin
        state_d = E_VIGILANCIA;
        load    = 1'b1;
      end
      E_VIGILANCIA: if (disp) begin
        state_d = E_ESPERA;
        load    = 1'b1;
        valor   = V_ENTRY;
      end
      // A trigger that goes away during the entry delay does not cancel it.
      E_ESPERA: if (cero) begin
        state_d = E_SONANDO;
        load    = 1'b1;
        valor   = V_SIREN;
      end
      E_SONANDO: if (cero) begin
        state_d = E_VIGILANCIA;
        load    = 1'b1;
      end
      default: begin
        state_d = E_DESARMADA;
        load    = 1'b1;
      end
    endcase
    // Disconnecting wins over every timed transition, including the one into
    // the siren, so a disconnect on the last entry cycle leaves no count.
    if (!bus.c && state_q != E_DESARMADA) begin
      state_d = E_DESARMADA;
      load    = 1'b1;
      valor   = '0;
    end
  end

  always_comb begin
    disparos_d = disparos_q;
    if (state_q == E_ESPERA && state_d == E_SONANDO && disparos_q != {CW{1'b1}}) begin
      disparos_d = disparos_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= E_DESARMADA;
      disparos_q <= '0;
    end else begin
      state_q    <= state_d;
      disparos_q <= disparos_d;
    end
  end

  assign bus.a        = (state_q == E_SONANDO);
  assign bus.aviso    = (state_q == E_ESPERA);
  assign bus.armada   = (state_q == E_VIGILANCIA) || (state_q == E_ESPERA) ||
                        (state_q == E_SONANDO);
  assign bus.disparos = disparos_q;

endmodule

// File: tb/tb_alarma_temporizada.sv
// tb_alarma_temporizada
// Directed bench for alarma_temporizada with NP=4, T_ARM=4, T_ENTRY=3,
// T_SIREN=5, CW=2. Each check compares {a, armada, aviso, disparos} against a
// hand-derived expectation, sampled 1 time unit after the rising edge.
module tb_alarma_temporizada;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  alarma_temporizada_if #(.NP(4), .CW(2)) bus ();

  alarma_temporizada #(
    .NP(4), .T_ARM(4), .T_ENTRY(3), .T_SIREN(5), .CW(2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // exp_v = {a, armada, aviso, disparos[1:0]}
  task automatic chk(input string tag, input logic [4:0] exp_v);
    logic [4:0] obs;
    obs = {bus.a, bus.armada, bus.aviso, bus.disparos};
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed {a,armada,aviso,disparos}=%b required %b", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Connect the alarm and check the T_ARM = 4 edge arming delay.
  task automatic arm(input string tag, input logic [1:0] d);
    bus.c = 1'b1;
    repeat (4) tick();
    chk({tag, "_armando"}, {1'b0, 1'b0, 1'b0, d});
    tick();
    chk({tag, "_armed"}, {1'b0, 1'b1, 1'b0, d});
  endtask

  initial begin
    logic ea, earm, eav;
    logic [1:0] ed;
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus.c = 1'b0; bus.p = 4'b0000; bus.t = 1'b0; bus.m = 1'b0; bus.f = 1'b1;

    // Reset state
    tick();
    chk("reset", 5'b00000);
    tick();
    @(negedge clk);
    reset_n = 1'b1;

    // 1: disconnected with the boot open never alarms
    bus.m = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("s1_c0_%0d", i), 5'b00000);
    end

    // 2: persistent trigger from arming: armed at 4, aviso 5-7, siren 8-12,
    //    aviso 14-16, siren again at 17
    bus.c = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      tick();
      ea   = (k >= 8 && k <= 12) || (k >= 17);
      eav  = (k >= 5 && k <= 7) || (k >= 14 && k <= 16);
      earm = (k >= 4);
      ed   = (k >= 17) ? 2'd2 : ((k >= 8) ? 2'd1 : 2'd0);
      chk($sformatf("s2_edge%0d", k), {ea, earm, eav, ed});
    end
    bus.c = 1'b0;
    bus.m = 1'b0;
    tick();
    chk("s2_disconnect", {1'b0, 1'b0, 1'b0, 2'd2});

    // 3: one-cycle trigger (door open, engine on, handbrake off) still sounds
    do_reset();
    arm("s3", 2'd0);
    bus.p = 4'b0010; bus.t = 1'b1; bus.f = 1'b0;
    tick();
    bus.p = 4'b0000; bus.t = 1'b0; bus.f = 1'b1;
    chk("s3_j0", {1'b0, 1'b1, 1'b1, 2'd0});
    for (int i = 1; i <= 8; i++) begin
      tick();
      ea  = (i >= 3 && i <= 7);
      eav = (i <= 2);
      ed  = (i >= 3) ? 2'd1 : 2'd0;
      chk($sformatf("s3_j%0d", i), {ea, 1'b1, eav, ed});
    end

    // 4a: disconnect on the second entry-delay cycle cancels the siren
    bus.m = 1'b1;
    tick();
    chk("s4a_esp0", {1'b0, 1'b1, 1'b1, 2'd1});
    tick();
    chk("s4a_esp1", {1'b0, 1'b1, 1'b1, 2'd1});
    bus.c = 1'b0;
    bus.m = 1'b0;
    tick();
    chk("s4a_cancel", {1'b0, 1'b0, 1'b0, 2'd1});
    tick();
    chk("s4a_after", {1'b0, 1'b0, 1'b0, 2'd1});

    // 4b: disconnect exactly when the entry delay expires: no siren, no count
    arm("s4b", 2'd1);
    bus.m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("s4b_esp%0d", i), {1'b0, 1'b1, 1'b1, 2'd1});
    end
    bus.c = 1'b0;
    tick();
    chk("s4b_cancel", {1'b0, 1'b0, 1'b0, 2'd1});
    tick();
    chk("s4b_after", {1'b0, 1'b0, 1'b0, 2'd1});

    // 5: four consecutive sirens, period 9 edges, count saturates at 3
    do_reset();
    bus.m = 1'b0;
    arm("s5", 2'd0);
    bus.m = 1'b1;
    for (int i = 0; i <= 30; i++) begin
      tick();
      for (int n = 0; n < 4; n++) begin
        if (i == 2 + 9 * n) begin
          ed = (n > 3) ? 2'd3 : 2'(n);
          chk($sformatf("s5_aviso%0d", n), {1'b0, 1'b1, 1'b1, ed});
        end
        if (i == 3 + 9 * n) begin
          ed = (n + 1 > 3) ? 2'd3 : 2'(n + 1);
          chk($sformatf("s5_siren%0d", n), {1'b1, 1'b1, 1'b0, ed});
        end
      end
    end

    // 6: asynchronous reset mid-siren silences immediately, then re-arming
    //    takes the full delay again
    #2;
    reset_n = 1'b0;
    #1;
    chk("s6_async", 5'b00000);
    #4;
    reset_n = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      tick();
      earm = (k == 4);
      chk($sformatf("s6_rearm%0d", k), {1'b0, earm, 1'b0, 2'd0});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
